// File: rtl/alut_age_sched.sv
// Aging sweep controller for the address lookup table: walks every entry via the
// age-side port, clears the valid bit of stale entries and counts how many it removed.
module alut_age_sched #(
  parameter int DW = 83,
  parameter int DD = 256,
  parameter int TW = 16
) (
  input  logic          pclk,
  input  logic          p_reset,
  input  logic          age_en,
  input  logic          sweep_start,
  input  logic [TW-1:0] cur_time,
  input  logic [TW-1:0] age_limit,
  input  logic [7:0]    mem_addr_add,
  input  logic          mem_write_add,
  input  logic [DW-1:0] mem_read_data_age,
  output logic [7:0]    mem_addr_age,
  output logic          mem_write_age,
  output logic [DW-1:0] mem_write_data_age,
  output logic          sweep_busy,
  output logic          sweep_done,
  output logic [8:0]    aged_count
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK, S_WR} state_t;

  localparam logic [7:0] LAST = 8'(DD - 1);

  state_t        state, state_nx;
  logic [7:0]    idx;
  logic          coll_rd;
  logic          hit, stale;
  logic          start, latch, commit, advance, abort, finish;
  logic [TW-1:0] stamp, age;

  // The index register doubles as the registered age-side address.
  assign mem_addr_age = idx;

  always_comb begin
    state_nx      = state;
    start         = 1'b0;
    latch         = 1'b0;
    commit        = 1'b0;
    advance       = 1'b0;
    abort         = 1'b0;
    finish        = 1'b0;
    hit           = mem_write_add && (mem_addr_add == idx);
    stamp         = mem_read_data_age[DW-2 -: TW];
    age           = cur_time - stamp;
    stale         = mem_read_data_age[DW-1] && (age > age_limit);
    mem_write_age = (state == S_WR) && !hit && !p_reset;

    case (state)
      S_IDLE: begin
        if (sweep_start && age_en && !sweep_done) begin
          start    = 1'b1;
          state_nx = S_RD;
        end
      end
      S_RD: state_nx = S_CHK;
      S_CHK: begin
        if (coll_rd || hit) begin
          state_nx = S_RD;
        end else if (stale) begin
          latch    = 1'b1;
          state_nx = S_WR;
        end else begin
          advance  = 1'b1;
        end
      end
      S_WR: begin
        if (hit) begin
          state_nx = S_RD;
        end else begin
          commit   = 1'b1;
          advance  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // A committed write in WR finishes before an age_en abort takes effect.
    if (advance) begin
      if (!age_en) begin
        abort    = 1'b1;
        state_nx = S_IDLE;
      end else if (idx == LAST) begin
        finish   = 1'b1;
        state_nx = S_IDLE;
      end else begin
        state_nx = S_RD;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state              <= S_IDLE;
      idx                <= '0;
      coll_rd            <= 1'b0;
      mem_write_data_age <= '0;
      sweep_busy         <= 1'b0;
      sweep_done         <= 1'b0;
      aged_count         <= '0;
    end else begin
      state      <= state_nx;
      coll_rd    <= (state == S_RD) && hit;
      sweep_done <= finish;
      if (start) begin
        idx        <= '0;
        aged_count <= '0;
        sweep_busy <= 1'b1;
      end
      if (finish || abort)
        sweep_busy <= 1'b0;
      if (advance && !abort && !finish)
        idx <= idx + 8'd1;
      if (commit)
        aged_count <= aged_count + 9'd1;
      if (latch)
        mem_write_data_age <= {1'b0, mem_read_data_age[DW-2:0]};
    end
  end

endmodule

// File: tb/tb_alut_age_sched.sv
// Bench for alut_age_sched: models the table memory and predicts each sweep's
// outcome from the aging rules applied to the loaded table image.
module tb_alut_age_sched;

  logic        pclk = 1'b0;
  logic        p_reset, age_en, sweep_start;
  logic [15:0] cur_time, age_limit;
  logic [7:0]  mem_addr_add;
  logic        mem_write_add;
  logic [82:0] rdata, add_data;
  logic [7:0]  mem_addr_age;
  logic        mem_write_age;
  logic [82:0] mem_write_data_age;
  logic        sweep_busy, sweep_done;
  logic [8:0]  aged_count;

  logic [82:0] mem  [256];
  logic [82:0] img  [256];
  logic [82:0] expm [256];
  logic [82:0] coll_data;
  int          age_writes = 0;
  int          checks = 0;
  int          errors = 0;

  alut_age_sched #(.DW(83), .DD(256), .TW(16)) dut (
    .pclk(pclk), .p_reset(p_reset), .age_en(age_en), .sweep_start(sweep_start),
    .cur_time(cur_time), .age_limit(age_limit),
    .mem_addr_add(mem_addr_add), .mem_write_add(mem_write_add),
    .mem_read_data_age(rdata), .mem_addr_age(mem_addr_age),
    .mem_write_age(mem_write_age), .mem_write_data_age(mem_write_data_age),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .aged_count(aged_count)
  );

  always #5 pclk = ~pclk;

  // Table memory with a registered read port on the age side.
  always @(posedge pclk) begin
    rdata <= mem[mem_addr_age];
    if (mem_write_age) begin
      mem[mem_addr_age] <= mem_write_data_age;
      age_writes        <= age_writes + 1;
    end
    if (mem_write_add)
      mem[mem_addr_add] <= add_data;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [82:0] mk(input bit v, input logic [15:0] st);
    logic [65:0] p;
    p = 66'({$urandom(), $urandom(), $urandom()});
    return {v, st, p};
  endfunction

  function automatic bit is_stale(input logic [82:0] e);
    int st, now, age;
    st  = int'(e[81:66]);
    now = int'(cur_time);
    age = (now - st + 65536) % 65536;
    return e[82] && (age > int'(age_limit));
  endfunction

  // Expected table after the sweep has handled entries 0..last; returns aged count.
  function automatic int build_exp(input int last);
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      expm[i] = img[i];
      if (i <= last && is_stale(img[i])) begin
        expm[i] = {1'b0, img[i][81:0]};
        n++;
      end
    end
    return n;
  endfunction

  task automatic check_mem(input string tag);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== expm[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (bad != 0) $display("table differs first at index %0d", first);
    check(tag, bad, 0);
  endtask

  task automatic load();
    for (int i = 0; i < 256; i++) begin
      mem_write_add = 1'b1;
      mem_addr_add  = 8'(i);
      add_data      = img[i];
      @(negedge pclk);
    end
    mem_write_add = 1'b0;
  endtask

  // Runs one sweep; cyc counts cycles from the first RD to done (or to busy low).
  task automatic sweep(input int coll_cyc, input int abort_cyc, input int busy_cyc,
                       output int cyc, output bit dn);
    sweep_start = 1'b1;
    @(negedge pclk);
    sweep_start = 1'b0;
    check("busy_rise", sweep_busy, 1'b1);
    cyc = 0;
    dn  = 1'b0;
    while (cyc < 3000) begin
      if (sweep_done) begin
        dn = 1'b1;
        break;
      end
      if (!sweep_busy) break;
      if (cyc == coll_cyc) begin
        mem_write_add = 1'b1;
        mem_addr_add  = 8'd7;
        add_data      = coll_data;
        #1 check("coll_suppress", mem_write_age, 1'b0);
      end
      if (cyc == abort_cyc) age_en = 1'b0;
      if (cyc == busy_cyc) sweep_start = 1'b1;
      @(negedge pclk);
      mem_write_add = 1'b0;
      sweep_start   = 1'b0;
      cyc++;
    end
    check("no_timeout", cyc < 3000, 1'b1);
  endtask

  task automatic full_sweep(input string tag, input int busy_cyc);
    int n, w0, cyc;
    bit dn;
    load();
    n  = build_exp(255);
    w0 = age_writes;
    sweep(-1, -1, busy_cyc, cyc, dn);
    check({tag, "_cycles"}, cyc, 512 + n);
    check({tag, "_done"}, dn, 1'b1);
    check({tag, "_busy_fall"}, sweep_busy, 1'b0);
    check({tag, "_count"}, aged_count, n);
    check({tag, "_writes"}, age_writes - w0, n);
    check_mem({tag, "_table"});
    @(negedge pclk);
    check({tag, "_done_pulse"}, sweep_done, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, mem_addr_age, 8'd0);
    check({tag, "_we"}, mem_write_age, 1'b0);
    check({tag, "_wdata"}, mem_write_data_age, 83'd0);
    check({tag, "_busy"}, sweep_busy, 1'b0);
    check({tag, "_done"}, sweep_done, 1'b0);
    check({tag, "_count"}, aged_count, 9'd0);
  endtask

  initial begin
    int n, w0, cyc;
    bit dn;
    p_reset = 1'b1; age_en = 1'b1; sweep_start = 1'b0;
    cur_time = 16'd0; age_limit = 16'd0;
    mem_addr_add = '0; mem_write_add = 1'b0; add_data = '0; coll_data = '0;
    repeat (3) @(negedge pclk);
    check_reset_outputs("reset");
    p_reset = 1'b0;
    @(negedge pclk);

    // All entries fresh (age 10, limit 100), with a stray start mid-sweep.
    cur_time  = 16'($urandom());
    age_limit = 16'd100;
    for (int i = 0; i < 256; i++) img[i] = mk(1'b1, cur_time - 16'd10);
    full_sweep("clean", 100);

    // Entries 3 and 255 just past the limit; others within it or invalid.
    for (int i = 0; i < 256; i++)
      img[i] = mk(1'($urandom()), cur_time - 16'($urandom_range(0, 100)));
    img[3]   = mk(1'b1, cur_time - 16'd101);
    img[255] = mk(1'b1, cur_time - 16'd101);
    full_sweep("two_stale", -1);
    check("two_stale_exact", aged_count, 9'd2);

    // Wrap-around age of 21 against limits 20 and 21; invalid entries of any age.
    cur_time = 16'h0005;
    for (int i = 0; i < 256; i++)
      img[i] = (i % 4 == 1) ? mk(1'b0, 16'($urandom())) : mk(1'b1, cur_time);
    img[9] = mk(1'b1, 16'hFFF0);
    age_limit = 16'd20;
    full_sweep("wrap20", -1);
    check("wrap20_aged", mem[9][82], 1'b0);
    age_limit = 16'd21;
    full_sweep("wrap21", -1);
    check("wrap21_kept", mem[9][82], 1'b1);

    // Fully random tables, limits and times.
    for (int r = 0; r < 2; r++) begin
      cur_time  = 16'($urandom());
      age_limit = 16'($urandom());
      for (int i = 0; i < 256; i++) img[i] = mk(1'($urandom()), 16'($urandom()));
      full_sweep("random", -1);
    end

    // Add-side write to entry 7 during its WR cycle; the fresh data survives.
    cur_time  = 16'($urandom());
    age_limit = 16'd50;
    for (int i = 0; i < 256; i++) img[i] = mk(1'b1, cur_time);
    img[7]   = mk(1'b1, cur_time - 16'd51);
    img[100] = mk(1'b1, cur_time - 16'd51);
    coll_data = mk(1'b1, cur_time);
    load();
    n = build_exp(255);
    expm[7] = coll_data;
    w0 = age_writes;
    sweep(16, -1, -1, cyc, dn);
    check("coll_cycles", cyc, 512 + (n - 1) + 3);
    check("coll_done", dn, 1'b1);
    check("coll_count", aged_count, n - 1);
    check("coll_writes", age_writes - w0, n - 1);
    check_mem("coll_table");
    @(negedge pclk);

    // Abort by dropping age_en at the RD of index 40 (two stale entries before it).
    for (int i = 0; i < 256; i++) img[i] = mk(1'b1, cur_time);
    img[10] = mk(1'b1, cur_time - 16'd60);
    img[20] = mk(1'b1, cur_time - 16'd60);
    img[50] = mk(1'b1, cur_time - 16'd60);
    load();
    n = build_exp(40);
    w0 = age_writes;
    sweep(-1, 2 * 40 + 2, -1, cyc, dn);
    check("abort_cycles", cyc, 2 * 40 + 2 + 2);
    check("abort_no_done", dn, 1'b0);
    check("abort_busy", sweep_busy, 1'b0);
    check("abort_count", aged_count, n);
    check("abort_writes", age_writes - w0, n);
    check_mem("abort_table");

    // Start request with aging disabled is ignored.
    sweep_start = 1'b1;
    @(negedge pclk);
    sweep_start = 1'b0;
    check("dis_busy", sweep_busy, 1'b0);
    repeat (3) @(negedge pclk);
    check("dis_busy_late", sweep_busy, 1'b0);
    check("dis_count_held", aged_count, 9'(n));
    age_en = 1'b1;

    // Reset landing on the WR cycle of stale entry 5.
    for (int i = 0; i < 256; i++) img[i] = mk(1'b1, cur_time);
    img[5] = mk(1'b1, cur_time - 16'd60);
    load();
    sweep_start = 1'b1;
    @(negedge pclk);
    sweep_start = 1'b0;
    repeat (12) @(negedge pclk);
    #1 check("wr_reached", mem_write_age, 1'b1);
    p_reset = 1'b1;
    #1 check("wr_reset_gate", mem_write_age, 1'b0);
    @(negedge pclk);
    check_reset_outputs("midreset");
    check("midreset_entry", mem[5], img[5]);
    p_reset = 1'b0;
    @(negedge pclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
